// File: rtl/cva5_exc_trace_buffer.sv
// ============================================================================
// cva5_exc_trace_buffer
// ----------------------------------------------------------------------------
// Purpose
//   Captures exception reports from the core into a small first-word-fall-
//   through FIFO so a debug/trace consumer can drain them at its own pace.
//   Every report, kept or dropped, consumes one sequence number. Gaps in the
//   m_seq stream therefore show the consumer exactly where records were lost.
//   When the FIFO is full a new report is dropped. The sticky overflow flag is
//   then set and the saturating drop counter increments. A registered stall
//   request tells the core to back off once occupancy reaches STALL_LEVEL.
//
// Parameters
//   XLEN        width of the tval / pc fields
//   DEPTH       number of FIFO entries (power of two, >= 2)
//   STALL_LEVEL occupancy at which o_dexie_stall asserts (1..DEPTH)
//   CNT_W       width of the sequence and drop counters
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_exc_valid    one exception record per high cycle
//   i_exc_code     exception cause
//   i_exc_tval     trap value
//   i_exc_pc       faulting pc
//   i_clear        synchronous flush of FIFO and statistics
//   o_m_valid      head record available (level != 0)
//   i_m_ready      consumer accepts the head record
//   o_m_code       head record cause
//   o_m_tval       head record trap value
//   o_m_pc         head record pc
//   o_m_seq        head record sequence number
//   o_level        current occupancy, 0..DEPTH
//   o_dexie_stall  registered core stall request
//   o_overflow     sticky: at least one record dropped since reset/clear
//   o_drop_count   saturating count of dropped records
// ============================================================================
module cva5_exc_trace_buffer #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 8,
   parameter int STALL_LEVEL = 6,
   parameter int CNT_W       = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,

   input  logic                     i_exc_valid,
   input  logic [4:0]               i_exc_code,
   input  logic [XLEN-1:0]          i_exc_tval,
   input  logic [XLEN-1:0]          i_exc_pc,

   input  logic                     i_clear,

   output logic                     o_m_valid,
   input  logic                     i_m_ready,
   output logic [4:0]               o_m_code,
   output logic [XLEN-1:0]          o_m_tval,
   output logic [XLEN-1:0]          o_m_pc,
   output logic [CNT_W-1:0]         o_m_seq,

   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_dexie_stall,
   output logic                     o_overflow,
   output logic [CNT_W-1:0]         o_drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0]    LP_DEPTH   = LW'(DEPTH);
   localparam logic [LW-1:0]    LP_STALL   = LW'(STALL_LEVEL);
   localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

   // -------------------------------------------------------------------------
   // Storage
   // -------------------------------------------------------------------------
   logic [4:0]       r_code [DEPTH];
   logic [XLEN-1:0]  r_tval [DEPTH];
   logic [XLEN-1:0]  r_pc   [DEPTH];
   logic [CNT_W-1:0] r_seq  [DEPTH];

   // -------------------------------------------------------------------------
   // Control state
   // -------------------------------------------------------------------------
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [CNT_W-1:0] r_seq_cnt;
   logic [CNT_W-1:0] r_drop_count;
   logic             r_overflow;
   logic             r_stall;

   logic             w_full;
   logic             w_not_empty;
   logic             w_report;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [LW-1:0]    w_level_nxt;

   assign w_full      = (r_level == LP_DEPTH);
   assign w_not_empty = (r_level != '0);

   // clear masks every event. A coincident report is neither stored nor
   // numbered, and a coincident m_ready does not pop.
   assign w_report = i_exc_valid & ~i_clear;
   assign w_pop    = w_not_empty & i_m_ready & ~i_clear;

   // A full FIFO still accepts a record when the head leaves in the same
   // cycle. The freed slot is the one being written next.
   assign w_push   = w_report & (~w_full | w_pop);
   assign w_drop   = w_report & w_full & ~w_pop;

   always_comb begin
      w_level_nxt = r_level;
      if (i_clear) begin
         w_level_nxt = '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Storage write port
   // NOTE: the record arrays are deliberately left out of reset. Validity is
   // carried entirely by r_level, so stale contents are never observable, and
   // an unreset array maps onto plain RAM/flop banks without reset fan-out.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_code[r_wr_ptr] <= i_exc_code;
         r_tval[r_wr_ptr] <= i_exc_tval;
         r_pc[r_wr_ptr]   <= i_exc_pc;
         r_seq[r_wr_ptr]  <= r_seq_cnt;
      end
   end

   // -------------------------------------------------------------------------
   // Pointers, occupancy, statistics
   // NOTE: all state here uses non-blocking assignments. Every register then
   // samples pre-edge values, which keeps level/pointer/counter updates
   // consistent with each other regardless of statement order.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_seq_cnt    <= '0;
         r_drop_count <= '0;
         r_overflow   <= 1'b0;
         r_stall      <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is the natural roll-over.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end

         r_level <= w_level_nxt;

         // Numbered on every report, stored or dropped.
         if (w_report) begin
            r_seq_cnt <= r_seq_cnt + CNT_W'(1);
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != LP_CNT_MAX) begin
               r_drop_count <= r_drop_count + CNT_W'(1);
            end
         end

         // Loaded from the next occupancy so the stall is registered and still
         // tracks o_level in the same cycle.
         r_stall <= (w_level_nxt >= LP_STALL);
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: the head entry is read combinationally, which gives
   // first-word-fall-through behaviour.
   // -------------------------------------------------------------------------
   assign o_m_valid     = w_not_empty;
   assign o_m_code      = r_code[r_rd_ptr];
   assign o_m_tval      = r_tval[r_rd_ptr];
   assign o_m_pc        = r_pc[r_rd_ptr];
   assign o_m_seq       = r_seq[r_rd_ptr];
   assign o_level       = r_level;
   assign o_dexie_stall = r_stall;
   assign o_overflow    = r_overflow;
   assign o_drop_count  = r_drop_count;

endmodule

// File: doc/cva5_exc_trace_buffer.md
CVA5_EXC_TRACE_BUFFER -- requirements
Module: cva5_exc_trace_buffer

Interface
- REQ-001: Parameter XLEN, default 32: width of the tval and pc fields.
- REQ-002: Parameter DEPTH, default 8: number of FIFO entries; power of two, at least 2.
- REQ-003: Parameter STALL_LEVEL, default 6: occupancy at which the core stall asserts; range 1..DEPTH.
- REQ-004: Parameter CNT_W, default 16: width of the sequence and drop counters.
- REQ-005: One clock; reset is synchronous and active-high.
- REQ-006: clk  in  1  clock.
- REQ-007: rst  in  1  synchronous active-high reset.
- REQ-008: exc_valid  in  1  core exception report, one record per high cycle.
- REQ-009: exc_code  in  5  exception cause.
- REQ-010: exc_tval  in  XLEN  trap value.
- REQ-011: exc_pc  in  XLEN  faulting pc.
- REQ-012: clear  in  1  synchronous flush of FIFO and statistics.
- REQ-013: m_valid  out  1  head record available.
- REQ-014: m_ready  in  1  consumer accepts head record.
- REQ-015: m_code / m_tval / m_pc  out  5 / XLEN / XLEN  head record fields.
- REQ-016: m_seq  out  CNT_W  sequence number of head record.
- REQ-017: level  out  clog2(DEPTH)+1  current occupancy.
- REQ-018: dexie_stall  out  1  core stall request.
- REQ-019: overflow  out  1  sticky: at least one record dropped.
- REQ-020: drop_count  out  CNT_W  saturating count of dropped records.

Function
- REQ-021: The block SHALL be a first-word-fall-through FIFO. A record pushed in cycle N SHALL appear at the head, with m_valid high, in cycle N+1 if the FIFO was empty.
- REQ-022: m_valid SHALL equal (level != 0). A pop occurs when m_valid and m_ready are both high. m_* fields are don't-care while m_valid is low, and SHALL be stable while m_valid is high and m_ready is low.
- REQ-023: A push occurs when exc_valid is high, clear is low, and either level < DEPTH or a pop occurs in the same cycle.
- REQ-024: Push and pop in the same cycle with the FIFO full SHALL both occur, leaving level at DEPTH. Push and pop in the same cycle with the FIFO at any other level SHALL leave level unchanged.
- REQ-025: exc_valid with level == DEPTH and no pop SHALL drop the record. The FIFO contents SHALL stay unchanged, overflow SHALL be set, and drop_count SHALL increment, saturating at 2^CNT_W-1.
- REQ-026: A sequence counter SHALL increment on every exc_valid cycle with clear low, whether the record is pushed or dropped, wrapping modulo 2^CNT_W. Each pushed record stores the pre-increment value as m_seq, so gaps in m_seq identify drops.
- REQ-027: Read and write pointers SHALL wrap modulo DEPTH. level SHALL update as level + push - pop and never exceed DEPTH or go below 0.
- REQ-028: dexie_stall SHALL be a register loaded each cycle with (next level >= STALL_LEVEL). It is therefore high in the same cycle that level first reads >= STALL_LEVEL, and low in the cycle level first drops below STALL_LEVEL.
- REQ-029: clear high SHALL, in the next cycle, set level to 0, pointers to 0, overflow to 0, drop_count to 0, sequence counter to 0 and dexie_stall to 0.
- REQ-030: clear SHALL take priority over push, pop and drop in the same cycle. A coincident exc_valid is discarded and not counted; a coincident m_ready has no effect.

Reset
- REQ-031: When rst is high at a clock edge, the next cycle SHALL have m_valid=0, level=0, dexie_stall=0, overflow=0, drop_count=0 and sequence counter=0.
- REQ-032: rst SHALL override clear, exc_valid and m_ready, including mid-stream with records buffered. Buffered records are discarded.
- REQ-033: FIFO storage needs no reset; m_code, m_tval, m_pc and m_seq are unspecified while m_valid=0.

Verification
- REQ-034: Single record: push code=2, tval=0xDEAD_BEEF, pc=0x0000_1000 with m_ready=0 -> next cycle m_valid=1, m_code=2, m_tval=0xDEAD_BEEF, m_pc=0x1000, m_seq=0, level=1; m_ready=1 for one cycle -> m_valid=0.
- REQ-035: Stall threshold (defaults), m_ready=0: push 6 records on consecutive cycles -> dexie_stall=0 while level=5 and 1 when level=6; one pop -> level=5 and dexie_stall=0 in that same cycle.
- REQ-036: Overflow: m_ready=0, 10 consecutive pushes -> level=8, drop_count=2, overflow=1; draining shows m_seq 0..7 in order with no gap, and the next push gets m_seq=10.
- REQ-037: Full FIFO, push and pop in the same cycle -> level stays 8, drop_count unchanged, new record appears at the tail.
- REQ-038: clear coincident with exc_valid at level=5, overflow=1 -> next cycle level=0, overflow=0, drop_count=0, dexie_stall=0; the next push gets m_seq=0.
- REQ-039: rst asserted with level=4 and dexie_stall=0 -> next cycle all outputs at reset values; a following push produces m_seq=0.
